// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel counters, registered HSync/VSync/output_en,
// and line/frame strobes. Define VGA_LOOKAHEAD_EN to add registered next_hcount/next_vcount/next_active.
module vga_timing_gen #(
  parameter int CNT_W       = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_SYNC_TRIM = 0,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             HSync,
  output logic             VSync,
  output logic             output_en,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0] next_hcount,
  output logic [CNT_W-1:0] next_vcount,
  output logic             next_active
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - H_SYNC_TRIM;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if ((2 ** CNT_W) < H_TOTAL) begin : g_bad_h_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL");
  end
  if ((2 ** CNT_W) < V_TOTAL) begin : g_bad_v_width
    $error("vga_timing_gen: CNT_W too narrow for V_TOTAL");
  end
  if (H_SYNC_TRIM >= H_SYNC) begin : g_bad_trim
    $error("vga_timing_gen: H_SYNC_TRIM must be smaller than H_SYNC");
  end

  function automatic logic [CNT_W-1:0] h_succ(input logic [CNT_W-1:0] h);
    return (h == H_LAST) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] v_succ(input logic [CNT_W-1:0] h,
                                              input logic [CNT_W-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + 1'b1;
  endfunction

  function automatic logic is_active(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  endfunction

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hs_on;
  logic             vs_on;

  // Syncs are decoded from the counts the tick is about to load, so the registered
  // pins line up with hcount/vcount on the same edge.
  always_comb begin
    h_nxt = h_succ(hcount);
    v_nxt = v_succ(hcount, vcount);
    hs_on = (int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END);
    vs_on = (int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      HSync       <= ~HSYNC_POL;
      VSync       <= ~VSYNC_POL;
      output_en   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hcount      <= h_nxt;
        vcount      <= v_nxt;
        HSync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
        VSync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        output_en   <= is_active(h_nxt, v_nxt);
        line_start  <= (h_nxt == '0);
        frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

`ifdef VGA_LOOKAHEAD_EN
  // Holds the position one tick beyond hcount/vcount; reset values are the first visible pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      next_hcount <= '0;
      next_vcount <= '0;
      next_active <= 1'b1;
    end else if (pix_en) begin
      next_hcount <= h_succ(h_nxt);
      next_vcount <= v_succ(h_nxt, v_nxt);
      next_active <= is_active(h_succ(h_nxt), v_succ(h_nxt, v_nxt));
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line-level timing and a
// small 16x8 instance (trimmed, active-high syncs) for frame-level timing.
module tb_vga_timing_gen;

  logic clk;
  logic reset_n;
  logic pix_en;

  logic [9:0] hc_d, vc_d;
  logic       hs_d, vs_d, oe_d, ls_d, fs_d;
  logic [3:0] hc_s, vc_s;
  logic       hs_s, vs_s, oe_s, ls_s, fs_s;
`ifdef VGA_LOOKAHEAD_EN
  logic [9:0] nh_d, nv_d;
  logic       na_d;
  logic [3:0] nh_s, nv_s;
  logic       na_s;
`endif

  vga_timing_gen #(.CNT_W(10)) u_dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc_d), .vcount(vc_d), .HSync(hs_d), .VSync(vs_d),
    .output_en(oe_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_LOOKAHEAD_EN
    , .next_hcount(nh_d), .next_vcount(nv_d), .next_active(na_d)
`endif
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_TRIM(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_sml (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hcount(hc_s), .vcount(vc_s), .HSync(hs_s), .VSync(vs_s),
    .output_en(oe_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_LOOKAHEAD_EN
    , .next_hcount(nh_s), .next_vcount(nv_s), .next_active(na_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fs = -1;
  int per_exp = 128;
  int mh_d, mv_d, mh_s, mv_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_d(input logic tick);
    int nh, nv;
    check("d_hcount", 32'(hc_d), mh_d);
    check("d_vcount", 32'(vc_d), mv_d);
    check("d_hsync", 32'(hs_d), (mh_d >= 656 && mh_d < 752) ? 0 : 1);
    check("d_vsync", 32'(vs_d), (mv_d >= 490 && mv_d < 492) ? 0 : 1);
    check("d_output_en", 32'(oe_d), (mh_d < 640 && mv_d < 480) ? 1 : 0);
    check("d_line_start", 32'(ls_d), (tick && mh_d == 0) ? 1 : 0);
    check("d_frame_start", 32'(fs_d), (tick && mh_d == 0 && mv_d == 0) ? 1 : 0);
    nh = (mh_d == 799) ? 0 : mh_d + 1;
    nv = (mh_d != 799) ? mv_d : ((mv_d == 524) ? 0 : mv_d + 1);
`ifdef VGA_LOOKAHEAD_EN
    check("d_next_hcount", 32'(nh_d), nh);
    check("d_next_vcount", 32'(nv_d), nv);
    check("d_next_active", 32'(na_d), (nh < 640 && nv < 480) ? 1 : 0);
`endif
  endtask

  task automatic check_s(input logic tick);
    int nh, nv;
    check("s_hcount", 32'(hc_s), mh_s);
    check("s_vcount", 32'(vc_s), mv_s);
    check("s_hsync", 32'(hs_s), (mh_s >= 10 && mh_s < 13) ? 1 : 0);
    check("s_vsync", 32'(vs_s), (mv_s >= 5 && mv_s < 7) ? 1 : 0);
    check("s_output_en", 32'(oe_s), (mh_s < 8 && mv_s < 4) ? 1 : 0);
    check("s_line_start", 32'(ls_s), (tick && mh_s == 0) ? 1 : 0);
    check("s_frame_start", 32'(fs_s), (tick && mh_s == 0 && mv_s == 0) ? 1 : 0);
    nh = (mh_s == 15) ? 0 : mh_s + 1;
    nv = (mh_s != 15) ? mv_s : ((mv_s == 7) ? 0 : mv_s + 1);
`ifdef VGA_LOOKAHEAD_EN
    check("s_next_hcount", 32'(nh_s), nh);
    check("s_next_vcount", 32'(nv_s), nv);
    check("s_next_active", 32'(na_s), (nh < 8 && nv < 4) ? 1 : 0);
`endif
  endtask

  task automatic step(input logic rst, input logic en);
    logic tick;
    reset_n = rst;
    pix_en  = en;
    @(posedge clk);
    #1;
    cyc++;
    tick = rst && en;
    if (!rst) begin
      mh_d = 799; mv_d = 524; mh_s = 15; mv_s = 7;
    end else if (en) begin
      if (mh_d == 799) begin mh_d = 0; mv_d = (mv_d == 524) ? 0 : mv_d + 1; end
      else mh_d++;
      if (mh_s == 15) begin mh_s = 0; mv_s = (mv_s == 7) ? 0 : mv_s + 1; end
      else mh_s++;
    end
    check_d(tick);
    check_s(tick);
    if (fs_s === 1'b1) begin
      if (last_fs >= 0) check("s_frame_period", 32'(cyc - last_fs), per_exp);
      last_fs = cyc;
    end
  endtask

  initial begin
    int n_hsl, n_oe, n_vsh, n_hsh;
    logic found;
    n_hsl = 0; n_oe = 0; n_vsh = 0; n_hsh = 0; found = 1'b0;
    reset_n = 1'b0;
    pix_en  = 1'b0;

    // Reset with and without pix_en
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Continuous ticks: two default lines, twelve-plus small frames
    per_exp = 128; last_fs = -1;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1, 1'b1);
      if (i < 800 && hs_d === 1'b0) n_hsl++;
      if (oe_d === 1'b1) n_oe++;
      if (i < 128) begin
        if (vs_s === 1'b1) n_vsh++;
        if (hs_s === 1'b1) n_hsh++;
      end
    end
    check("d_hsync_width_line0", 32'(n_hsl), 96);
    check("d_output_en_2lines", 32'(n_oe), 1280);
    check("s_vsync_clks_frame", 32'(n_vsh), 32);
    check("s_hsync_clks_frame", 32'(n_hsh), 24);

    // pix_en toggling 1,0,1,0: frame period doubles
    per_exp = 256; last_fs = -1;
    for (int i = 0; i < 800; i++) step(1'b1, (i % 2) == 0);

    // Run to small (5,3), then a one-clk reset mid-frame
    per_exp = 128; last_fs = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1);
      if (mh_s == 5 && mv_s == 3) found = 1'b1;
    end
    check("s_reach_mid", 32'(found), 1);
    step(1'b0, 1'b1);
    last_fs = -1;
    step(1'b1, 1'b1);
    check("d_first_after_reset", {30'd0, fs_d, ls_d}, 3);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
